// File: rtl/box_ave_pkg.sv
// Shared constants and helper functions for the multi-lane box averager.
// Optional round-half-up output is enabled by defining BOX_AVE_ROUNDING_EN.
package box_ave_pkg;

    localparam int DEF_ADC_WIDTH      = 8;
    localparam int DEF_CHANNELS       = 2;
    localparam int DEF_MAX_DEPTH_BITS = 4;
    localparam int DEF_DEPTH_SEL_W    = 3;
    localparam int ACC_W              = DEF_ADC_WIDTH + DEF_MAX_DEPTH_BITS;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    // Requested exponents above the supported maximum saturate to the maximum.
    function automatic int clamp_depth(input int sel, input int max_depth);
        return (sel > max_depth) ? max_depth : sel;
    endfunction

    function automatic int round_term(input int depth);
        return (depth > 0) ? (1 << (depth - 1)) : 0;
    endfunction

endpackage

// File: rtl/box_ave_lane.sv
// One averaging lane: input data register, window accumulator and output register.
// Output rounding follows BOX_AVE_ROUNDING_EN (round-half-up) or truncates by default.
module box_ave_lane
    import box_ave_pkg::*;
#(
    parameter int ADC_WIDTH      = DEF_ADC_WIDTH,
    parameter int MAX_DEPTH_BITS = DEF_MAX_DEPTH_BITS,
    parameter int DEPTH_SEL_W    = DEF_DEPTH_SEL_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   accumulate,
    input  logic                   first,
    input  logic                   latch,
    input  logic [DEPTH_SEL_W-1:0] depth,
    input  logic [ADC_WIDTH-1:0]   data,
    output logic [ADC_WIDTH-1:0]   ave
);

    localparam int LANE_ACC_W = ADC_WIDTH + MAX_DEPTH_BITS;

    logic [ADC_WIDTH-1:0]  data_d1;
    logic [LANE_ACC_W-1:0] acc;
    logic [LANE_ACC_W-1:0] rounded;
    logic [ADC_WIDTH-1:0]  result;

    // The accumulator width covers 2^MAX_DEPTH_BITS full-scale samples plus the
    // rounding term, so neither the add nor the shifted result can overflow.
    always_comb begin
`ifdef BOX_AVE_ROUNDING_EN
        rounded = acc + LANE_ACC_W'(round_term(int'(depth)));
`else
        rounded = acc;
`endif
        result = ADC_WIDTH'(rounded >> depth);
    end

    // NOTE: state updates use non-blocking assignments so every register samples
    // pre-edge values; using blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_d1 <= '0;
            acc     <= '0;
            ave     <= '0;
        end else begin
            data_d1 <= data;
            if (accumulate) begin
                acc <= first ? LANE_ACC_W'(data_d1) : acc + LANE_ACC_W'(data_d1);
            end
            if (latch) begin
                ave <= result;
            end
        end
    end

endmodule

// File: rtl/box_ave_multi.sv
// Multi-lane box averager: shared strobe edge detector, window counter and depth latch.
// Define BOX_AVE_ROUNDING_EN for round-half-up averages instead of truncation.
module box_ave_multi
    import box_ave_pkg::*;
#(
    parameter int ADC_WIDTH      = DEF_ADC_WIDTH,
    parameter int CHANNELS       = DEF_CHANNELS,
    parameter int MAX_DEPTH_BITS = DEF_MAX_DEPTH_BITS,
    parameter int DEPTH_SEL_W    = DEF_DEPTH_SEL_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample,
    input  logic                          clear,
    input  logic [DEPTH_SEL_W-1:0]        depth_sel,
    input  logic [CHANNELS*ADC_WIDTH-1:0] raw_data_in,
    output logic [CHANNELS*ADC_WIDTH-1:0] ave_data_out,
    output logic                          data_out_valid,
    output logic [DEPTH_SEL_W-1:0]        active_depth
);

    localparam int CNT_W = MAX_DEPTH_BITS + 1;

    if (DEPTH_SEL_W < clog2(MAX_DEPTH_BITS + 1)) begin : g_bad_cfg
        $error("DEPTH_SEL_W too narrow for MAX_DEPTH_BITS");
    end

    logic                   sample_d1;
    logic                   sample_d2;
    logic                   accumulate;
    logic                   acc_en;
    logic                   first;
    logic                   last;
    logic                   latch;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       term_count;
    logic [DEPTH_SEL_W-1:0] req_depth;
    logic [DEPTH_SEL_W-1:0] eff_depth;

    // A window's length is fixed by the depth captured at its first sample; a
    // first sample therefore compares against the newly requested depth.
    always_comb begin
        accumulate = sample_d1 & ~sample_d2;
        acc_en     = accumulate & ~clear;
        first      = (count == '0);
        req_depth  = DEPTH_SEL_W'(clamp_depth(int'(depth_sel), MAX_DEPTH_BITS));
        eff_depth  = first ? req_depth : active_depth;
        term_count = CNT_W'((1 << eff_depth) - 1);
        last       = (count == term_count);
    end

    // The strobe history resets high so a strobe held through reset is not
    // mistaken for a fresh rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_d1      <= 1'b1;
            sample_d2      <= 1'b1;
            count          <= '0;
            latch          <= 1'b0;
            data_out_valid <= 1'b0;
            active_depth   <= DEPTH_SEL_W'(MAX_DEPTH_BITS);
        end else begin
            sample_d1      <= sample;
            sample_d2      <= sample_d1;
            latch          <= acc_en & last;
            data_out_valid <= latch;
            if (clear) begin
                count <= '0;
            end else if (accumulate) begin
                if (first) begin
                    active_depth <= req_depth;
                end
                count <= last ? '0 : count + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        box_ave_lane #(
            .ADC_WIDTH      (ADC_WIDTH),
            .MAX_DEPTH_BITS (MAX_DEPTH_BITS),
            .DEPTH_SEL_W    (DEPTH_SEL_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .accumulate (acc_en),
            .first      (first),
            .latch      (latch),
            .depth      (active_depth),
            .data       (raw_data_in[k*ADC_WIDTH +: ADC_WIDTH]),
            .ave        (ave_data_out[k*ADC_WIDTH +: ADC_WIDTH])
        );
    end

endmodule

// File: tb/tb_box_ave_multi.sv
// Directed self-checking bench for box_ave_multi (2 lanes x 8 bits, max depth 4).
// Expected averages honour BOX_AVE_ROUNDING_EN when the bench is built with it.
module tb_box_ave_multi;

    localparam int ADC_WIDTH      = 8;
    localparam int CHANNELS       = 2;
    localparam int MAX_DEPTH_BITS = 4;
    localparam int DEPTH_SEL_W    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample = 1'b0;
    logic        clear = 1'b0;
    logic [2:0]  depth_sel = 3'd2;
    logic [15:0] raw_data_in = '0;
    logic [15:0] ave_data_out;
    logic        data_out_valid;
    logic [2:0]  active_depth;

    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    int cyc = 0;
    int last_cap = 0;
    int last_valid_cyc = -1;

    box_ave_multi #(
        .ADC_WIDTH      (ADC_WIDTH),
        .CHANNELS       (CHANNELS),
        .MAX_DEPTH_BITS (MAX_DEPTH_BITS),
        .DEPTH_SEL_W    (DEPTH_SEL_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample         (sample),
        .clear          (clear),
        .depth_sel      (depth_sel),
        .raw_data_in    (raw_data_in),
        .ave_data_out   (ave_data_out),
        .data_out_valid (data_out_valid),
        .active_depth   (active_depth)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_out_valid === 1'b1) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
        end
    end

    // One strobe: high across one capture edge, then low for one cycle.
    task automatic send(input logic [7:0] l1, input logic [7:0] l0);
        raw_data_in = {l1, l0};
        sample = 1'b1;
        @(posedge clk); #1;
        last_cap = cyc;
        sample = 1'b0;
        @(posedge clk); #1;
    endtask

    // Strobe whose accumulate cycle coincides with clear.
    task automatic send_clr(input logic [7:0] l1, input logic [7:0] l0);
        raw_data_in = {l1, l0};
        sample = 1'b1;
        @(posedge clk); #1;
        sample = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ave_data_out !== 16'h0000) begin
            failures++; $display("FAIL reset_ave: got %h expected 0000", ave_data_out);
        end
        checks++;
        if (data_out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b expected 0", data_out_valid);
        end
        checks++;
        if (active_depth !== 3'd4) begin
            failures++; $display("FAIL reset_depth: got %0d expected 4", active_depth);
        end
    endtask

    task automatic test_basic();
        int v0;
        depth_sel = 3'd2;
        v0 = valid_cnt;
        send(8'd255, 8'd10);
        send(8'd255, 8'd20);
        send(8'd255, 8'd30);
        settle();
        checks++;
        if (valid_cnt - v0 !== 0) begin
            failures++; $display("FAIL basic_early_valid: got %0d pulses expected 0", valid_cnt - v0);
        end
        send(8'd255, 8'd40);
        settle();
        checks++;
        if (valid_cnt - v0 !== 1) begin
            failures++; $display("FAIL basic_valid_count: got %0d expected 1", valid_cnt - v0);
        end
        checks++;
        if (last_valid_cyc !== last_cap + 2) begin
            failures++; $display("FAIL basic_latency: got %0d cycles expected 2", last_valid_cyc - last_cap);
        end
        checks++;
        if (ave_data_out !== {8'd255, 8'd25}) begin
            failures++; $display("FAIL basic_ave: got %h expected %h", ave_data_out, {8'd255, 8'd25});
        end
        checks++;
        if (active_depth !== 3'd2) begin
            failures++; $display("FAIL basic_depth: got %0d expected 2", active_depth);
        end
    endtask

    task automatic test_small_depth();
        int v0;
        logic [15:0] exp_d1;
`ifdef BOX_AVE_ROUNDING_EN
        exp_d1 = {8'd101, 8'd2};
`else
        exp_d1 = {8'd100, 8'd1};
`endif
        depth_sel = 3'd1;
        v0 = valid_cnt;
        send(8'd100, 8'd1);
        send(8'd101, 8'd2);
        settle();
        checks++;
        if (ave_data_out !== exp_d1) begin
            failures++; $display("FAIL d1_ave: got %h expected %h", ave_data_out, exp_d1);
        end
        checks++;
        if (valid_cnt - v0 !== 1) begin
            failures++; $display("FAIL d1_valid: got %0d expected 1", valid_cnt - v0);
        end
        depth_sel = 3'd0;
        v0 = valid_cnt;
        send(8'd5, 8'd77);
        settle();
        checks++;
        if (ave_data_out !== {8'd5, 8'd77}) begin
            failures++; $display("FAIL d0_ave_a: got %h expected %h", ave_data_out, {8'd5, 8'd77});
        end
        checks++;
        if (valid_cnt - v0 !== 1) begin
            failures++; $display("FAIL d0_valid_a: got %0d expected 1", valid_cnt - v0);
        end
        send(8'd9, 8'd200);
        settle();
        checks++;
        if (ave_data_out !== {8'd9, 8'd200}) begin
            failures++; $display("FAIL d0_ave_b: got %h expected %h", ave_data_out, {8'd9, 8'd200});
        end
        checks++;
        if (valid_cnt - v0 !== 2) begin
            failures++; $display("FAIL d0_valid_b: got %0d expected 2", valid_cnt - v0);
        end
    endtask

    task automatic test_depth_change();
        int v0;
        depth_sel = 3'd2;
        v0 = valid_cnt;
        send(8'd0, 8'd4);
        send(8'd0, 8'd8);
        depth_sel = 3'd0;
        #1;
        checks++;
        if (active_depth !== 3'd2) begin
            failures++; $display("FAIL chg_depth_mid: got %0d expected 2", active_depth);
        end
        send(8'd0, 8'd12);
        settle();
        checks++;
        if (valid_cnt - v0 !== 0) begin
            failures++; $display("FAIL chg_early_valid: got %0d expected 0", valid_cnt - v0);
        end
        send(8'd0, 8'd16);
        settle();
        checks++;
        if (valid_cnt - v0 !== 1) begin
            failures++; $display("FAIL chg_valid: got %0d expected 1", valid_cnt - v0);
        end
        checks++;
        if (ave_data_out !== {8'd0, 8'd10}) begin
            failures++; $display("FAIL chg_ave: got %h expected %h", ave_data_out, {8'd0, 8'd10});
        end
        send(8'd33, 8'd50);
        settle();
        checks++;
        if (active_depth !== 3'd0) begin
            failures++; $display("FAIL chg_depth_new: got %0d expected 0", active_depth);
        end
        checks++;
        if (ave_data_out !== {8'd33, 8'd50}) begin
            failures++; $display("FAIL chg_ave_d0: got %h expected %h", ave_data_out, {8'd33, 8'd50});
        end
        checks++;
        if (valid_cnt - v0 !== 2) begin
            failures++; $display("FAIL chg_valid_d0: got %0d expected 2", valid_cnt - v0);
        end
    endtask

    task automatic test_clear();
        int v0;
        depth_sel = 3'd2;
        v0 = valid_cnt;
        send(8'd1, 8'd1);
        send(8'd1, 8'd1);
        send(8'd1, 8'd1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        settle();
        checks++;
        if (valid_cnt - v0 !== 0) begin
            failures++; $display("FAIL clr_valid: got %0d expected 0", valid_cnt - v0);
        end
        checks++;
        if (ave_data_out !== {8'd33, 8'd50}) begin
            failures++; $display("FAIL clr_hold: got %h expected %h", ave_data_out, {8'd33, 8'd50});
        end
        for (int i = 0; i < 4; i++) send(8'd8, 8'd8);
        settle();
        checks++;
        if (valid_cnt - v0 !== 1) begin
            failures++; $display("FAIL clr_next_valid: got %0d expected 1", valid_cnt - v0);
        end
        checks++;
        if (ave_data_out !== {8'd8, 8'd8}) begin
            failures++; $display("FAIL clr_next_ave: got %h expected %h", ave_data_out, {8'd8, 8'd8});
        end
        v0 = valid_cnt;
        send_clr(8'd200, 8'd200);
        send(8'd4, 8'd16);
        send(8'd4, 8'd20);
        send(8'd4, 8'd24);
        settle();
        checks++;
        if (valid_cnt - v0 !== 0) begin
            failures++; $display("FAIL clr_coinc_early: got %0d expected 0", valid_cnt - v0);
        end
        send(8'd4, 8'd28);
        settle();
        checks++;
        if (valid_cnt - v0 !== 1) begin
            failures++; $display("FAIL clr_coinc_valid: got %0d expected 1", valid_cnt - v0);
        end
        checks++;
        if (ave_data_out !== {8'd4, 8'd22}) begin
            failures++; $display("FAIL clr_coinc_ave: got %h expected %h", ave_data_out, {8'd4, 8'd22});
        end
    endtask

    task automatic test_held_strobe();
        int v0;
        depth_sel = 3'd0;
        v0 = valid_cnt;
        raw_data_in = {8'd1, 8'd99};
        sample = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        sample = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (valid_cnt - v0 !== 1) begin
            failures++; $display("FAIL held_valid: got %0d expected 1", valid_cnt - v0);
        end
        checks++;
        if (ave_data_out !== {8'd1, 8'd99}) begin
            failures++; $display("FAIL held_ave: got %h expected %h", ave_data_out, {8'd1, 8'd99});
        end
        v0 = valid_cnt;
        raw_data_in = {8'd2, 8'd44};
        sample = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (valid_cnt - v0 !== 0) begin
            failures++; $display("FAIL held_rst_valid: got %0d expected 0", valid_cnt - v0);
        end
        checks++;
        if (ave_data_out !== 16'h0000) begin
            failures++; $display("FAIL held_rst_ave: got %h expected 0000", ave_data_out);
        end
        checks++;
        if (active_depth !== 3'd4) begin
            failures++; $display("FAIL held_rst_depth: got %0d expected 4", active_depth);
        end
        sample = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(8'd7, 8'd123);
        settle();
        checks++;
        if (valid_cnt - v0 !== 1) begin
            failures++; $display("FAIL held_after_valid: got %0d expected 1", valid_cnt - v0);
        end
        checks++;
        if (ave_data_out !== {8'd7, 8'd123}) begin
            failures++; $display("FAIL held_after_ave: got %h expected %h", ave_data_out, {8'd7, 8'd123});
        end
    endtask

    task automatic test_clamp_reset();
        int v0;
        depth_sel = 3'd7;
        v0 = valid_cnt;
        for (int i = 0; i < 15; i++) send(8'd3, 8'd100);
        settle();
        checks++;
        if (active_depth !== 3'd4) begin
            failures++; $display("FAIL clamp_depth: got %0d expected 4", active_depth);
        end
        checks++;
        if (valid_cnt - v0 !== 0) begin
            failures++; $display("FAIL clamp_early: got %0d expected 0", valid_cnt - v0);
        end
        send(8'd3, 8'd100);
        settle();
        checks++;
        if (valid_cnt - v0 !== 1) begin
            failures++; $display("FAIL clamp_valid: got %0d expected 1", valid_cnt - v0);
        end
        checks++;
        if (ave_data_out !== {8'd3, 8'd100}) begin
            failures++; $display("FAIL clamp_ave: got %h expected %h", ave_data_out, {8'd3, 8'd100});
        end
        v0 = valid_cnt;
        for (int i = 0; i < 9; i++) send(8'd9, 8'd50);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
        checks++;
        if (ave_data_out !== 16'h0000) begin
            failures++; $display("FAIL midrst_ave: got %h expected 0000", ave_data_out);
        end
        checks++;
        if (data_out_valid !== 1'b0) begin
            failures++; $display("FAIL midrst_valid_lvl: got %b expected 0", data_out_valid);
        end
        checks++;
        if (valid_cnt - v0 !== 0) begin
            failures++; $display("FAIL midrst_valid: got %0d expected 0", valid_cnt - v0);
        end
        checks++;
        if (active_depth !== 3'd4) begin
            failures++; $display("FAIL midrst_depth: got %0d expected 4", active_depth);
        end
        depth_sel = 3'd1;
        send(8'd1, 8'd6);
        send(8'd3, 8'd8);
        settle();
        checks++;
        if (ave_data_out !== {8'd2, 8'd7}) begin
            failures++; $display("FAIL midrst_clean_ave: got %h expected %h", ave_data_out, {8'd2, 8'd7});
        end
        checks++;
        if (valid_cnt - v0 !== 1) begin
            failures++; $display("FAIL midrst_clean_valid: got %0d expected 1", valid_cnt - v0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_small_depth();
        test_depth_change();
        test_clear();
        test_held_strobe();
        test_clamp_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
